// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: hold levels,
// controller states and the instruction address width.
package pipe_ctrl_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned HOLD_FLAG_W = 3;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;

  // Hold levels consumed by the stage registers; higher value freezes more stages
  typedef enum logic [HOLD_FLAG_W-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_flag_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_FLUSH
  } state_e;

  // Resolve the hold level from the two independent request classes
  function automatic hold_flag_e hold_level(input logic need_id, input logic need_pc);
    if (need_id)      return HOLD_ID;
    else if (need_pc) return HOLD_PC;
    else              return HOLD_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the core stages and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic                   jump_flag_i;
  inst_addr_t             jump_addr_i;
  logic                   hold_ex_i;
  logic                   hold_bus_i;
  logic                   hold_clint_i;
  logic                   int_assert_i;
  inst_addr_t             int_addr_i;
  logic                   cnt_clr_i;
  logic [HOLD_FLAG_W-1:0] hold_flag_o;
  logic                   jump_flag_o;
  inst_addr_t             jump_addr_o;
  logic [CNT_W-1:0]       stall_cnt_o;

  // Controller side
  modport slave (
    input  jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, hold_clint_i,
           int_assert_i, int_addr_i, cnt_clr_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, stall_cnt_o
  );

  // Requester side (core stages / bench)
  modport master (
    output jump_flag_i, jump_addr_i, hold_ex_i, hold_bus_i, hold_clint_i,
           int_assert_i, int_addr_i, cnt_clr_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, reusable for perf counters.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over increment; the count sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stall and redirect requests into a
// single hold level and PC redirect, defers jumps across bus stalls and
// counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e     r_state;
  logic [2:0] r_flush_cnt;
  inst_addr_t r_pend_addr;

  logic       w_redirect;
  inst_addr_t w_redir_addr;
  logic       w_pend_take;
  hold_flag_e w_hold;

  // Redirect source selection: interrupt, then ex jump, then release of a pended jump
  always_comb begin
    w_redirect   = 1'b0;
    w_redir_addr = '0;
    w_pend_take  = 1'b0;
    if (bus.int_assert_i) begin
      w_redirect   = 1'b1;
      w_redir_addr = bus.int_addr_i;
    end else if (bus.jump_flag_i && (r_state != ST_PEND)) begin
      if ((r_state == ST_IDLE) && bus.hold_bus_i) begin
        w_pend_take = 1'b1;
      end else begin
        w_redirect   = 1'b1;
        w_redir_addr = bus.jump_addr_i;
      end
    end else if ((r_state == ST_PEND) && !bus.hold_bus_i) begin
      w_redirect   = 1'b1;
      w_redir_addr = r_pend_addr;
    end
  end

  // Hold level: flush/ex/clint/redirect freeze up to ID, bus stall or pending jump freeze PC
  always_comb begin
    w_hold = hold_level(bus.hold_ex_i || bus.hold_clint_i || w_redirect || (r_state == ST_FLUSH),
                        bus.hold_bus_i || (r_state == ST_PEND));
  end

  assign bus.hold_flag_o = w_hold;
  assign bus.jump_flag_o = w_redirect;
  assign bus.jump_addr_o = w_redir_addr;

  // Sequencing FSM with pend register and flush countdown; any redirect restarts the flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_pend_addr <= '0;
    end else if (w_redirect) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= FLUSH_LOAD;
      r_pend_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pend_take) begin
            r_state     <= ST_PEND;
            r_pend_addr <= bus.jump_addr_i;
          end
        end
        ST_PEND: begin
          r_state <= ST_PEND;
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) r_state     <= ST_IDLE;
          else                   r_flush_cnt <= r_flush_cnt - 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_hold != HOLD_NONE),
    .clr   (bus.cnt_clr_i),
    .count (bus.stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic,
// expected outputs from a cycle-indexed reference model, checked by a monitor.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) u_if16 ();
  pipe_ctrl_if #(.CNT_W(4))  u_if4 ();

  assign u_if4.jump_flag_i  = u_if16.jump_flag_i;
  assign u_if4.jump_addr_i  = u_if16.jump_addr_i;
  assign u_if4.hold_ex_i    = u_if16.hold_ex_i;
  assign u_if4.hold_bus_i   = u_if16.hold_bus_i;
  assign u_if4.hold_clint_i = u_if16.hold_clint_i;
  assign u_if4.int_assert_i = u_if16.int_assert_i;
  assign u_if4.int_addr_i   = u_if16.int_addr_i;
  assign u_if4.cnt_clr_i    = u_if16.cnt_clr_i;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(16)) u_dut (
    .clk (clk), .rst (rst), .bus (u_if16.slave)
  );
  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) u_dut4 (
    .clk (clk), .rst (rst), .bus (u_if4.slave)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  hold;
    logic        jf;
    logic [31:0] ja;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a redirect at cycle t forces Hold_Id up to cycle t+FC
  bit          m_pend;
  logic [31:0] m_pend_addr;
  int          m_cyc = 0;
  int          m_flush_until = -1;
  int unsigned m_cnt16 = 0;
  int unsigned m_cnt4  = 0;

  task automatic step(input logic jf, input logic [31:0] ja, input logic ex,
                      input logic hbus, input logic clint, input logic ia,
                      input logic [31:0] iaddr, input logic clr, input logic r);
    exp_t        e;
    bit          flushing, redir, pend_before, need_id, need_pc;
    logic [31:0] ra;
    @(negedge clk);
    rst                 = r;
    u_if16.jump_flag_i  = jf;
    u_if16.jump_addr_i  = ja;
    u_if16.hold_ex_i    = ex;
    u_if16.hold_bus_i   = hbus;
    u_if16.hold_clint_i = clint;
    u_if16.int_assert_i = ia;
    u_if16.int_addr_i   = iaddr;
    u_if16.cnt_clr_i    = clr;
    e.cyc = m_cyc;
    if (r) begin
      m_pend = 0; m_pend_addr = '0; m_flush_until = -1;
      m_cnt16 = 0; m_cnt4 = 0;
      e.hold = '0; e.jf = 1'b0; e.ja = '0; e.c16 = '0; e.c4 = '0;
    end else begin
      flushing    = (m_cyc <= m_flush_until);
      pend_before = m_pend;
      redir = 0; ra = '0;
      if (ia) begin
        redir = 1; ra = iaddr; m_pend = 0;
      end else if (jf && !pend_before) begin
        if (!flushing && hbus) begin
          m_pend = 1; m_pend_addr = ja;
        end else begin
          redir = 1; ra = ja;
        end
      end else if (pend_before && !hbus) begin
        redir = 1; ra = m_pend_addr; m_pend = 0;
      end
      if (redir) m_flush_until = m_cyc + int'(FC);
      need_id = ex || clint || redir || flushing;
      need_pc = hbus || pend_before;
      e.hold = need_id ? 3'd3 : (need_pc ? 3'd1 : 3'd0);
      e.jf   = redir;
      e.ja   = ra;
      e.c16  = m_cnt16[15:0];
      e.c4   = m_cnt4[3:0];
      if (clr) begin
        m_cnt16 = 0; m_cnt4 = 0;
      end else if (e.hold != 3'd0) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15)     m_cnt4++;
      end
    end
    q.push_back(e);
    m_cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("hold_flag", e.cyc, 32'(u_if16.hold_flag_o), 32'(e.hold));
        chk("jump_flag", e.cyc, 32'(u_if16.jump_flag_o), 32'(e.jf));
        chk("jump_addr", e.cyc, u_if16.jump_addr_o, e.ja);
        chk("stall_cnt16", e.cyc, 32'(u_if16.stall_cnt_o), 32'(e.c16));
        chk("stall_cnt4", e.cyc, 32'(u_if4.stall_cnt_o), 32'(e.c4));
      end
    end
  end

  // Stimulus: directed scenarios followed by random traffic
  initial begin
    logic bus_lvl;
    logic r, jf, ex, cl, ia, clr;
    u_if16.jump_flag_i = 0; u_if16.jump_addr_i = '0; u_if16.hold_ex_i = 0;
    u_if16.hold_bus_i = 0; u_if16.hold_clint_i = 0; u_if16.int_assert_i = 0;
    u_if16.int_addr_i = '0; u_if16.cnt_clr_i = 0;

    // reset, single jump to 0x100
    step(0, '0, 0, 0, 0, 0, '0, 0, 1);
    step(0, '0, 0, 0, 0, 0, '0, 0, 1);
    idle(2);
    step(1, 32'h100, 0, 0, 0, 0, '0, 0, 0);
    idle(4);
    // jump during a 5-cycle bus hold
    step(0, '0, 0, 1, 0, 0, '0, 0, 0);
    step(1, 32'h200, 0, 1, 0, 0, '0, 0, 0);
    step(0, '0, 0, 1, 0, 0, '0, 0, 0);
    step(1, 32'h250, 0, 1, 0, 0, '0, 0, 0);
    step(0, '0, 0, 1, 0, 0, '0, 0, 0);
    idle(4);
    // interrupt and jump together
    step(1, 32'h300, 0, 0, 0, 1, 32'h80, 0, 0);
    idle(4);
    // interrupt while a jump is pending
    step(1, 32'h400, 0, 1, 0, 0, '0, 0, 0);
    step(0, '0, 0, 1, 0, 0, '0, 0, 0);
    step(0, '0, 0, 1, 0, 1, 32'h80, 0, 0);
    step(0, '0, 0, 1, 0, 0, '0, 0, 0);
    idle(4);
    // ex hold with a second jump in the second flush cycle
    step(1, 32'h500, 1, 0, 0, 0, '0, 0, 0);
    step(0, '0, 1, 0, 0, 0, '0, 0, 0);
    step(1, 32'h600, 1, 0, 0, 0, '0, 0, 0);
    step(0, '0, 1, 0, 0, 0, '0, 0, 0);
    idle(4);
    // saturation, clear, reset mid-FLUSH and mid-PEND
    for (int i = 0; i < 20; i++) step(0, '0, 1, 0, 0, 0, '0, 0, 0);
    step(0, '0, 0, 0, 0, 0, '0, 1, 0);
    idle(2);
    step(1, 32'h700, 0, 0, 0, 0, '0, 0, 0);
    step(0, '0, 0, 0, 0, 0, '0, 0, 1);
    idle(3);
    step(1, 32'h800, 0, 1, 0, 0, '0, 0, 0);
    step(0, '0, 0, 1, 0, 0, '0, 0, 0);
    step(0, '0, 0, 0, 0, 0, '0, 0, 1);
    idle(4);

    // random traffic with bursty bus holds
    bus_lvl = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) bus_lvl = ~bus_lvl;
      r   = ($urandom_range(0, 99) == 0);
      jf  = ($urandom_range(0, 4) == 0);
      ex  = ($urandom_range(0, 7) == 0);
      cl  = ($urandom_range(0, 15) == 0);
      ia  = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 31) == 0);
      if (r) step(0, '0, 0, 0, 0, 0, '0, 0, 1);
      else   step(jf, $urandom & 32'hFFFF_FFFC, ex, bus_lvl, cl, ia,
                  $urandom & 32'hFFFF_FFFC, clr, 0);
    end
    idle(2);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", m_cyc, 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage core. Collects stall requests from the execute unit, the bus arbiter and the CLINT, and redirect requests from execute and interrupts. Drives the single `hold_flag_o` level consumed by pc_reg, if2id, id2ex and the other stage registers, plus the PC redirect. Jumps that arrive during a bus stall are held in a small FSM until the bus releases, and a cycle counter reports stall cycles for performance monitoring.

## Interface
- `FLUSH_CYCLES`, default 2: cycles of `Hold_Id` forced after every redirect so the stage registers inject `INST_NOP`. Legal range 1–7.
- `CNT_W`, default 16: width of the stall counter.

Ports (clock and reset first):
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `jump_flag_i`  in  1  branch/jump taken, from ex.
- `jump_addr_i`  in  32  branch/jump target.
- `hold_ex_i`  in  1  multi-cycle op busy (mul/div).
- `hold_bus_i`  in  1  instruction bus is granted to another master.
- `hold_clint_i`  in  1  CLINT CSR save/restore in progress.
- `int_assert_i`  in  1  interrupt entry or mret redirect, one-cycle pulse.
- `int_addr_i`  in  32  interrupt/mret target.
- `cnt_clr_i`  in  1  synchronous clear of the stall counter.
- `hold_flag_o`  out  3  one of `Hold_None`=0, `Hold_Pc`=1, `Hold_If`=2, `Hold_Id`=3.
- `jump_flag_o`  out  1  PC redirect strobe to pc_reg.
- `jump_addr_o`  out  32  redirect target.
- `stall_cnt_o`  out  `CNT_W`  saturating count of cycles with `hold_flag_o`≠0.

## Operation
- The FSM has three states: IDLE, PEND and FLUSH.
- **Redirect source selection** (combinational, in priority order):
  1. `int_assert_i` → `int_addr_i`.
  2. `jump_flag_i` → `jump_addr_i`.
  3. In PEND, when `hold_bus_i`=0 → the pending address.
  - Interrupt and jump together: the interrupt wins and the ex jump is discarded.
- **IDLE:**
  - A jump while `hold_bus_i`=1 → latch `jump_addr_i` into `pend_addr` and go to PEND. No redirect is issued.
  - Any redirect issued (interrupt always, jump when the bus is free) → `jump_flag_o`=1 this cycle, load `flush_cnt`=`FLUSH_CYCLES`-1, go to FLUSH.
- **PEND:**
  - `hold_flag_o` is forced to at least `Hold_Pc`.
  - `int_assert_i`=1 → the interrupt redirect is issued, `pend_addr` is dropped, go to FLUSH.
  - `hold_bus_i` falls → redirect to `pend_addr`, go to FLUSH.
  - Further ex jumps are ignored while in PEND, because the front end is frozen.
- **FLUSH:**
  - `hold_flag_o` is forced to `Hold_Id`.
  - `flush_cnt` decrements each cycle; the FSM returns to IDLE when it is 0.
  - A new redirect during FLUSH is issued immediately and reloads `flush_cnt`.
- **Hold level:** `hold_flag_o` is the maximum of:
  - `Hold_Id` if `hold_ex_i`, `hold_clint_i`, a redirect this cycle, or state FLUSH.
  - `Hold_Pc` if `hold_bus_i` or state PEND.
  - Otherwise `Hold_None`.
- **Stall counter:**
  - Increments when `hold_flag_o`≠0.
  - Saturates at all-ones and does not wrap.
  - `cnt_clr_i` has priority over increment: the counter is 0 in the next cycle.

## Timing
- Reset values:
  - state=IDLE, `flush_cnt`=0, `pend_addr`=0, `stall_cnt_o`=0.
  - `hold_flag_o`=0, `jump_flag_o`=0, `jump_addr_o`=0.
- `hold_flag_o`, `jump_flag_o` and `jump_addr_o` are combinational from inputs and registered state: zero-cycle latency, as pc_reg requires.
- `jump_addr_o`=0 whenever `jump_flag_o`=0.
- A redirect from IDLE causes exactly `FLUSH_CYCLES`+1 cycles of `Hold_Id` (the issuing cycle plus `FLUSH_CYCLES`), absent other holds.
- A pended jump is redirected in the first cycle in which `hold_bus_i`=0. Added latency equals the bus-hold length.
- Reset asserted mid-FLUSH or mid-PEND clears the state; the pending jump is lost.
- `stall_cnt_o` is registered and lags `hold_flag_o` by one cycle.

## Structure
- The hold encodings `Hold_None`/`Hold_Pc`/`Hold_If`/`Hold_Id`, `Hold_Flag_Bus`, `InstAddrBus` and the state encodings belong in the shared `define.v`.
- Sub-module `sat_counter` (parameter `W`; ports: inc, clr, count) is natural and reusable for other perf counters.
- The FSM, pend register and flush counter are inline.

## Test plan
- Reset with `FLUSH_CYCLES`=2, then `jump_flag_i`=1 for one cycle with target 0x100 → in that cycle `jump_flag_o`=1 and `jump_addr_o`=0x100; `hold_flag_o`=3 for 3 cycles, then 0; `stall_cnt_o`=3.
- `hold_bus_i`=1 for 5 cycles; jump to 0x200 in the 2nd cycle → `hold_flag_o`=1 through the bus hold with no redirect; redirect to 0x200 in the first cycle bus hold is low; then 2 flush cycles.
- `int_assert_i` (0x80) and `jump_flag_i` (0x300) in the same cycle → redirect to 0x80 only; 0x300 is never issued.
- In PEND (target 0x400), `int_assert_i` (0x80) while the bus is still held → redirect to 0x80; no later 0x400 redirect.
- `hold_ex_i` for 4 cycles, then a jump in the 2nd flush cycle → `hold_flag_o`=3 throughout; the second jump issues at once and the flush count restarts.
- Force the counter near saturation with `CNT_W`=4 and 20 hold cycles → `stall_cnt_o` stays at 15; `cnt_clr_i` → 0 in the next cycle; `rst` mid-FLUSH → all outputs 0 immediately.
